// File: rtl/rtc_pkg.sv
// Shared constants for the RTC programming datapath: field-select codes,
// per-field legal ranges and the step kinds chosen by each counter instance.
package rtc_pkg;

  localparam int BCD_W = 4;

  localparam logic [3:0] SEL_SS_T  = 4'd8;
  localparam logic [3:0] SEL_MM_T  = 4'd9;
  localparam logic [3:0] SEL_HH_T  = 4'd10;
  localparam logic [3:0] SEL_DAY_T = 4'd11;
  localparam logic [3:0] SEL_MON_T = 4'd12;

  localparam int SS_MIN  = 0;
  localparam int SS_MAX  = 59;
  localparam int MM_MIN  = 0;
  localparam int MM_MAX  = 59;
  localparam int HH_MIN  = 0;
  localparam int HH_MAX  = 23;
  localparam int DAY_MIN = 1;
  localparam int DAY_MAX = 31;
  localparam int MON_MIN = 1;
  localparam int MON_MAX = 12;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_LOAD = 2'd3
  } step_e;

endpackage

// File: rtl/contador_ad_rango_bcd_if.sv
// Control/status bundle of one range counter; the programming FSM and the
// cascade neighbours drive the master side, the counter is the slave.
interface contador_ad_rango_bcd_if #(
  parameter int W    = 6,
  parameter int NDIG = 2
);
  // All request inputs are single-cycle pulses sampled on the rising edge;
  // there is no ready/backpressure, every pulse is acted on or discarded in
  // the cycle it is seen.
  logic [3:0]        en_count;
  logic              enUP;
  logic              enDOWN;
  logic              inc_in;
  logic              dec_in;
  logic              load_en;
  logic [W-1:0]      load_val;
  logic [W-1:0]      count_bin;
  logic [4*NDIG-1:0] data_bcd;
  logic              carry_out;
  logic              borrow_out;

  modport master (
    output en_count, enUP, enDOWN, inc_in, dec_in, load_en, load_val,
    input  count_bin, data_bcd, carry_out, borrow_out
  );

  modport slave (
    input  en_count, enUP, enDOWN, inc_in, dec_in, load_en, load_val,
    output count_bin, data_bcd, carry_out, borrow_out
  );
endinterface

// File: rtl/contador_ad_rango_bcd_bin_a_bcd.sv
// Combinational binary to packed BCD conversion (double-dabble), most
// significant digit in the top nibble.
module bin_a_bcd
  import rtc_pkg::*;
#(
  parameter int W    = 6,
  parameter int NDIG = 2
) (
  input  logic [W-1:0]          bin_i,
  output logic [BCD_W*NDIG-1:0] bcd_o
);

  logic [BCD_W*NDIG-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = W - 1; i >= 0; i--) begin
      // Pre-correct any digit that would exceed 9 after the next shift.
      for (int d = 0; d < NDIG; d++) begin
        if (acc[BCD_W*d +: BCD_W] >= 4'd5) begin
          acc[BCD_W*d +: BCD_W] = acc[BCD_W*d +: BCD_W] + 4'd3;
        end
      end
      acc = {acc[BCD_W*NDIG-2:0], bin_i[i]};
    end
  end

  assign bcd_o = acc;

endmodule

// File: rtl/contador_ad_rango_bcd.sv
// Up/down counter over [MIN_VAL, MAX_VAL] with load, cascade and manual edit
// inputs, registered wrap pulses and a BCD view of the count.
module contador_ad_rango_bcd
  import rtc_pkg::*;
#(
  parameter int         W         = 6,
  parameter int         MIN_VAL   = SS_MIN,
  parameter int         MAX_VAL   = SS_MAX,
  parameter logic [3:0] FIELD_SEL = SEL_SS_T,
  parameter int         NDIG      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  contador_ad_rango_bcd_if.slave  bus
);

  if (MAX_VAL >= 2**W || MIN_VAL > MAX_VAL || MIN_VAL < 0 || MAX_VAL >= 10**NDIG) begin : g_bad_params
    $error("contador_ad_rango_bcd: illegal W/MIN_VAL/MAX_VAL/NDIG combination");
  end

  localparam logic [W-1:0] MIN_W = W'(MIN_VAL);
  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

  logic [W-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  step_e        step;
  int           cnt_v;
  int           load_v;

  // Signed 32-bit copies keep range compares free of unsigned-zero corner cases.
  assign cnt_v  = int'(count_q);
  assign load_v = int'(bus.load_val);

  always_comb begin
    step = STEP_HOLD;
    if (bus.load_en) begin
      step = STEP_LOAD;
    end else if (bus.inc_in || bus.dec_in) begin
      // Cascade owns the cycle; a coincident manual edit is dropped.
      if (bus.inc_in && !bus.dec_in) step = STEP_INC;
      else if (bus.dec_in && !bus.inc_in) step = STEP_DEC;
    end else if (bus.en_count == FIELD_SEL) begin
      if (bus.enUP && !bus.enDOWN) step = STEP_INC;
      else if (bus.enDOWN && !bus.enUP) step = STEP_DEC;
    end
  end

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    case (step)
      STEP_LOAD: begin
        if (load_v > MAX_VAL)      count_d = MAX_W;
        else if (load_v < MIN_VAL) count_d = MIN_W;
        else                       count_d = bus.load_val;
      end
      STEP_INC: begin
        if (cnt_v >= MAX_VAL) begin
          count_d = MIN_W;
          carry_d = 1'b1;
        end else if (cnt_v < MIN_VAL) begin
          count_d = MIN_W;
        end else begin
          count_d = count_q + W'(1);
        end
      end
      STEP_DEC: begin
        if (cnt_v > MAX_VAL) begin
          count_d = MAX_W;
        end else if (cnt_v <= MIN_VAL) begin
          count_d  = MAX_W;
          borrow_d = 1'b1;
        end else begin
          count_d = count_q - W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= MIN_W;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  logic [BCD_W*NDIG-1:0] bcd;

  bin_a_bcd #(
    .W    (W),
    .NDIG (NDIG)
  ) u_bin_a_bcd (
    .bin_i (count_q),
    .bcd_o (bcd)
  );

  assign bus.count_bin  = count_q;
  assign bus.data_bcd   = bcd;
  assign bus.carry_out  = carry_q;
  assign bus.borrow_out = borrow_q;

endmodule
